iir_tdf2_seq: RTL and testbench
===============================

IIR_TDF2_SEQ -- requirements
Module: iir_tdf2_seq

Interface
REQ-001 SHALL provide parameter ORDER, default 5, filter order N, legal range 1..8.
REQ-002 SHALL provide parameter DATA_W, default 16, signed width of x and y.
REQ-003 SHALL provide parameter COEF_W, default 18, signed coefficient width.
REQ-004 SHALL provide parameter FRAC, default 15, coefficient fractional bits (1.0 = 2^FRAC).
REQ-005 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL provide port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL provide port x  input  DATA_W  signed input sample.
REQ-008 SHALL provide port in_valid  input  1  x is valid this cycle.
REQ-009 SHALL provide port in_ready  output  1  block accepts a sample this cycle.
REQ-010 SHALL provide port y  output  DATA_W  signed registered output sample.
REQ-011 SHALL provide port out_valid  output  1  one-cycle pulse, y holds a new sample.
REQ-012 SHALL provide port coef_we  input  1  coefficient write strobe.
REQ-013 SHALL provide port coef_addr  input  5  bit4=0: b[addr[3:0]]; bit4=1: a[addr[3:0]].
REQ-014 SHALL provide port coef_data  input  COEF_W  signed coefficient value.

Function
REQ-015 SHALL implement transposed direct form II: y = (b0*x + s1)>>>FRAC; s_k = b_k*x + s_(k+1) - a_k*y for k=1..N-1; s_N = b_N*x - a_N*y; a0 implicitly 1.0.
REQ-016 SHALL use one time-shared multiply-accumulate path; internal accumulator/state width ACC_W = DATA_W+COEF_W+4, full precision, no intermediate rounding.
REQ-017 SHALL scale y by arithmetic right shift of FRAC bits (floor truncation) and use the scaled DATA_W value of y in the a_k*y feedback terms.
REQ-018 SHALL have FSM states IDLE, CALC, UPD; IDLE->CALC on handshake, CALC->UPD after one cycle, UPD stays N cycles (k=1..N ascending) then ->IDLE.
REQ-019 SHALL assert in_ready = (state==IDLE) and not coef_we; handshake = in_valid and in_ready; x latched on handshake edge.
REQ-020 SHALL register y and pulse out_valid for exactly one cycle, starting 2 cycles after the handshake edge; y holds its value until the next sample.
REQ-021 SHALL sustain one sample per N+2 cycles with in_valid held high.
REQ-022 SHALL apply UPD step k using s_(k+1) from the previous sample (ascending order guarantees this); s values change only in UPD.
REQ-023 SHALL write coefficients only in IDLE; coef_we outside IDLE, or index > N (or a-index 0), SHALL be ignored with no effect.
REQ-024 SHALL give coef_we priority over a simultaneous in_valid in IDLE (no handshake that cycle).
REQ-025 SHALL ignore in_valid while not in IDLE; no sample is buffered or dropped silently beyond in_ready semantics.

Reset
REQ-026 SHALL, while reset is low at a rising edge, set state=IDLE, all s_k=0, y=0, out_valid=0; in_ready is 1 in the first cycle after release.
REQ-027 SHALL on reset load identity coefficients: b0=2^FRAC, all other b_k and a_k = 0.
REQ-028 SHALL abort any in-progress sample on reset mid-CALC/UPD with no out_valid pulse afterwards.

Configuration
REQ-029 SHALL, with macro IIR_TDF2_SAT_EN defined, saturate y to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before registering and before feedback.
REQ-030 SHALL, without IIR_TDF2_SAT_EN, wrap y (keep low DATA_W bits of the shifted result); all other behaviour identical.

Verification
REQ-031 SHALL test identity: reset release, x=1000 handshake -> out_valid 2 cycles later, y=1000; next in_ready at N+2 cycles after handshake.
REQ-032 SHALL test FIR: ORDER=1, b0=b1=16384, a1=0, x=32767 then 0 -> y=16383, then 16383, then 0.
REQ-033 SHALL test recursion: ORDER=1, b0=32768, b1=0, a1=-16384, x step 1000 -> y=1000, 1500, 1750, 1875.
REQ-034 SHALL test saturation: b0=65536, x=20000 -> y=32767 with IIR_TDF2_SAT_EN, y=-25536 without.
REQ-035 SHALL test busy-write: coef_we with b0=0 during UPD ignored -> next x=500 yields y=500 (identity).
REQ-036 SHALL test reset mid-UPD: reset low one cycle -> no out_valid, in_ready=1 after release, x=7 -> y=7.

Source files
------------

// File: rtl/iir_tdf2_seq.sv
// Sequential transposed direct form II IIR filter: one sample per ORDER+2 cycles.
// Define IIR_TDF2_SAT_EN to saturate y to the DATA_W range; otherwise y wraps.
module iir_tdf2_seq #(
  parameter int ORDER  = 5,
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int FRAC   = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] y,
  output logic                     out_valid,
  input  logic                     coef_we,
  input  logic [4:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data
);

  localparam int ACC_W  = DATA_W + COEF_W + 4;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int K_W    = 4;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC);

  typedef enum logic [1:0] {IDLE, CALC, UPD} state_t;

  state_t                   state_q;
  logic [K_W-1:0]           k_q;
  logic signed [COEF_W-1:0] b_q [0:ORDER];
  logic signed [COEF_W-1:0] a_q [1:ORDER];
  logic signed [ACC_W-1:0]  s_q [1:ORDER];
  logic signed [DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] yfb_q;
  logic signed [DATA_W-1:0] y_q;
  logic                     out_valid_q;

  logic [K_W-1:0]           k_idx;
  logic signed [COEF_W-1:0] b_sel;
  logic signed [COEF_W-1:0] a_sel;
  logic signed [ACC_W-1:0]  s_sel;
  logic signed [PROD_W-1:0] prod_b;
  logic signed [PROD_W-1:0] prod_a;
  logic signed [ACC_W-1:0]  mac_d;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] y_d;

  // Shared MAC: step 0 (CALC) forms b0*x + s1, step k forms b_k*x + s_(k+1) - a_k*y.
  always_comb begin
    k_idx = (state_q == CALC) ? '0 : k_q;
    b_sel = '0;
    a_sel = '0;
    s_sel = '0;
    for (int i = 0; i <= ORDER; i++) begin
      if (k_idx == K_W'(i)) b_sel = b_q[i];
    end
    for (int i = 1; i <= ORDER; i++) begin
      if (k_idx == K_W'(i)) a_sel = a_q[i];
    end
    for (int i = 0; i < ORDER; i++) begin
      if (k_idx == K_W'(i)) s_sel = s_q[i+1];
    end
    prod_b  = b_sel * x_q;
    prod_a  = a_sel * yfb_q;
    mac_d   = ACC_W'(prod_b) + s_sel - ACC_W'(prod_a);
    shifted = mac_d >>> FRAC;
  end

`ifdef IIR_TDF2_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - ACC_W'(1);

  always_comb begin
    if (shifted > Y_MAX)      y_d = DATA_W'(Y_MAX);
    else if (shifted < Y_MIN) y_d = DATA_W'(Y_MIN);
    else                      y_d = DATA_W'(shifted);
  end
`else
  always_comb begin
    y_d = DATA_W'(shifted);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      x_q         <= '0;
      yfb_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i <= ORDER; i++) b_q[i] <= (i == 0) ? COEF_ONE : '0;
      for (int i = 1; i <= ORDER; i++) a_q[i] <= '0;
      for (int i = 1; i <= ORDER; i++) s_q[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A coefficient write blocks the handshake; out-of-range indices fall through the loops.
          if (coef_we) begin
            if (!coef_addr[4]) begin
              for (int i = 0; i <= ORDER; i++)
                if (coef_addr[3:0] == 4'(i)) b_q[i] <= coef_data;
            end else begin
              for (int i = 1; i <= ORDER; i++)
                if (coef_addr[3:0] == 4'(i)) a_q[i] <= coef_data;
            end
          end else if (in_valid) begin
            x_q     <= x;
            state_q <= CALC;
          end
        end
        CALC: begin
          yfb_q   <= y_d;
          k_q     <= K_W'(1);
          state_q <= UPD;
        end
        UPD: begin
          for (int i = 1; i <= ORDER; i++)
            if (k_q == K_W'(i)) s_q[i] <= mac_d;
          if (k_q == K_W'(1)) begin
            y_q         <= yfb_q;
            out_valid_q <= 1'b1;
          end
          if (k_q == K_W'(ORDER)) state_q <= IDLE;
          else                    k_q     <= k_q + K_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !coef_we;
  assign y         = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_iir_tdf2_seq.sv
// Self-checking bench for iir_tdf2_seq: directed scenarios plus random coefficients/samples
// compared against a direct-form-I history model (honours IIR_TDF2_SAT_EN).
module tb_iir_tdf2_seq;

  localparam int N    = 5;
  localparam int FRAC = 15;

  logic               clk;
  logic               reset;
  logic signed [15:0] x;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] y;
  logic               out_valid;
  logic               coef_we;
  logic [4:0]         coef_addr;
  logic signed [17:0] coef_data;

  int compared   = 0;
  int mismatched = 0;

  longint bM [0:N];
  longint aM [0:N];
  longint xH [0:N];
  longint yH [0:N];

  longint yGot;
  longint yExp;
  longint rv;
  int     cnt;

  iir_tdf2_seq #(.ORDER(N), .DATA_W(16), .COEF_W(18), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k <= N; k++) begin
      bM[k] = 0; aM[k] = 0; xH[k] = 0; yH[k] = 0;
    end
    bM[0] = 64'sd1 <<< FRAC;
  endfunction

  // y[n] = floor((sum b_k x[n-k] - sum a_k y[n-k]) / 2^FRAC), then clamp or wrap to 16 bits.
  function automatic longint modelStep(input longint xn);
    longint acc;
    longint yv;
    for (int k = N; k > 0; k--) xH[k] = xH[k-1];
    xH[0] = xn;
    acc = 0;
    for (int k = 0; k <= N; k++) acc += bM[k] * xH[k];
    for (int k = 1; k <= N; k++) acc -= aM[k] * yH[k];
    yv = acc >>> FRAC;
`ifdef IIR_TDF2_SAT_EN
    if (yv > 32767) yv = 32767;
    if (yv < -32768) yv = -32768;
`else
    yv = yv & 64'hFFFF;
    if (yv >= 32768) yv -= 65536;
`endif
    for (int k = N; k > 1; k--) yH[k] = yH[k-1];
    yH[1] = yv;
    return yv;
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    modelReset();
  endtask

  task automatic writeCoef(input bit isA, input int idx, input longint val, input bit apply);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = {isA, idx[3:0]};
    coef_data = val[17:0];
    @(negedge clk);
    coef_we = 1'b0;
    if (apply) begin
      if (!isA && idx <= N) bM[idx] = val;
      else if (isA && idx >= 1 && idx <= N) aM[idx] = val;
    end
  endtask

  // Handshake one sample and check the single out_valid pulse two edges later.
  task automatic applyStimulus(input longint xv, output longint yv);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    x = xv[15:0];
    in_valid = 1'b1;
    while (!in_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("handshake_wait", longint'(waitCnt < 100), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("out_valid_e0", longint'(out_valid), 0);
    @(negedge clk);
    checkOutput("out_valid_e1", longint'(out_valid), 0);
    @(negedge clk);
    checkOutput("out_valid_e2", longint'(out_valid), 1);
    yv = y;
    @(negedge clk);
    checkOutput("out_valid_e3", longint'(out_valid), 0);
  endtask

  task automatic sampleExpect(input string tag, input longint xv, input longint exp);
    longint got;
    longint unused;
    applyStimulus(xv, got);
    unused = modelStep(xv);
    checkOutput(tag, got, exp);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
    x = '0; coef_addr = '0; coef_data = '0;

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_in_ready", longint'(in_ready), 1);
    checkOutput("rst_out_valid", longint'(out_valid), 0);
    checkOutput("rst_y", longint'(y), 0);

    $display("[TB] identity and throughput");
    sampleExpect("identity_y", 1000, 1000);
    doReset();
    @(negedge clk);
    x = 16'sd1000;
    in_valid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!in_ready && cnt < 50);
    in_valid = 1'b0;
    checkOutput("next_in_ready_cycles", cnt, N + 2);
    checkOutput("held_valid_y", longint'(y), 1000);

    $display("[TB] FIR");
    doReset();
    writeCoef(0, 0, 16384, 1);
    writeCoef(0, 1, 16384, 1);
    sampleExpect("fir_y0", 32767, 16383);
    sampleExpect("fir_y1", 0, 16383);
    sampleExpect("fir_y2", 0, 0);

    $display("[TB] recursion");
    doReset();
    writeCoef(0, 0, 32768, 1);
    writeCoef(1, 1, -16384, 1);
    sampleExpect("rec_y0", 1000, 1000);
    sampleExpect("rec_y1", 1000, 1500);
    sampleExpect("rec_y2", 1000, 1750);
    sampleExpect("rec_y3", 1000, 1875);

    $display("[TB] saturation");
    doReset();
    writeCoef(0, 0, 65536, 1);
`ifdef IIR_TDF2_SAT_EN
    sampleExpect("sat_y", 20000, 32767);
`else
    sampleExpect("wrap_y", 20000, -25536);
`endif

    $display("[TB] busy write");
    doReset();
    sampleExpect("busy_pre_y", 300, 300);
    writeCoef(0, 0, 0, 0);
    sampleExpect("busy_y", 500, 500);

    $display("[TB] write priority and illegal indices");
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    in_valid = 1'b1; coef_we = 1'b1; coef_addr = 5'd0; coef_data = 18'sd32768;
    #1;
    checkOutput("prio_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    #1;
    checkOutput("prio_still_idle", longint'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("prio_no_sample", longint'(out_valid), 0);
    end
    writeCoef(1, 0, 12345, 1);
    writeCoef(0, 6, 5000, 1);
    writeCoef(0, 15, 5000, 1);
    sampleExpect("illegal_idx_y", 77, 77);

    $display("[TB] reset mid-update");
    doReset();
    @(negedge clk);
    x = 16'sd1234;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    checkOutput("abort_out_valid", longint'(out_valid), 0);
    checkOutput("abort_in_ready", longint'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_no_pulse", longint'(out_valid), 0);
    end
    sampleExpect("abort_y", 7, 7);

    $display("[TB] random coefficients and samples");
    doReset();
    for (int k = 0; k <= N; k++) begin
      rv = longint'($urandom_range(0, 80000)) - 40000;
      writeCoef(0, k, rv, 1);
    end
    for (int k = 1; k <= N; k++) begin
      rv = longint'($urandom_range(0, 40000)) - 20000;
      writeCoef(1, k, rv, 1);
    end
    for (int i = 0; i < 24; i++) begin
      rv = longint'($urandom_range(0, 65535)) - 32768;
      applyStimulus(rv, yGot);
      yExp = modelStep(rv);
      checkOutput("random_y", yGot, yExp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
